// File: rtl/fnn_pkg.sv
// Shared definitions for the FNN layer blocks.
//   DataWidth     : default weight word width, shared with the weight memories
//   wload_state_e : weight loader FSM states
//   onehot()      : index to one-hot decode (results up to MaxOneHot bits wide)
package fnn_pkg;

  localparam int unsigned DataWidth = 16;
  localparam int unsigned MaxOneHot = 256;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StFinish
  } wload_state_e;

  // Callers size-cast the result down to their own enable width.
  function automatic logic [MaxOneHot-1:0] onehot(input int unsigned idx);
    return {{(MaxOneHot - 1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/wload_counter.sv
// Nested address/neuron counter for the weight loader.
//   clk, rst    : clock, synchronous active-high reset
//   clear       : force both counters to zero
//   advance     : step to the next weight slot (one accepted beat)
//   addr_cnt    : address within the current neuron memory
//   neuron_cnt  : current neuron memory
//   last        : current slot is the final one of the layer
module wload_counter
  import fnn_pkg::*;
#(
  parameter int unsigned NumNeuron   = 8,
  parameter int unsigned NumWeight   = 30,
  parameter int unsigned AddrWidth   = 5,
  parameter int unsigned NeuronWidth = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   advance,
  output logic [AddrWidth-1:0]   addr_cnt,
  output logic [NeuronWidth-1:0] neuron_cnt,
  output logic                   last
);

  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [NeuronWidth-1:0] neuron_q, neuron_d;
  logic                   addr_wrap, neuron_wrap;

  assign addr_wrap   = (addr_q == AddrWidth'(NumWeight - 1));
  assign neuron_wrap = (neuron_q == NeuronWidth'(NumNeuron - 1));

  always_comb begin
    addr_d   = addr_q;
    neuron_d = neuron_q;
    if (clear) begin
      addr_d   = '0;
      neuron_d = '0;
    end else if (advance) begin
      if (addr_wrap) begin
        addr_d   = '0;
        // Wrapping the neuron count after the final slot keeps it in range.
        neuron_d = neuron_wrap ? '0 : neuron_q + NeuronWidth'(1);
      end else begin
        addr_d = addr_q + AddrWidth'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      neuron_q <= '0;
    end else begin
      addr_q   <= addr_d;
      neuron_q <= neuron_d;
    end
  end

  assign addr_cnt   = addr_q;
  assign neuron_cnt = neuron_q;
  assign last       = addr_wrap && neuron_wrap;

endmodule

// File: rtl/weight_loader.sv
// Streams weights into the per-neuron weight memories of one FNN layer,
// neuron-major (neuron 0 addr 0..NUM_WEIGHT-1, then neuron 1, ...).
//   clk, rst        : clock, synchronous active-high reset
//   start           : begin a load (honoured only when idle)
//   s_valid/s_ready : weight stream handshake, s_data is the weight word
//   wen/wadd/win    : memory write port, one wen bit per neuron memory
//   busy            : load in progress
//   done            : one-cycle pulse with the final write
//   checksum        : wrapping sum of the accepted words when WLOAD_CHECKSUM_EN
//                     is defined, otherwise tied to zero
module weight_loader
  import fnn_pkg::*;
#(
  parameter int unsigned NUM_NEURON = 8,
  parameter int unsigned NUM_WEIGHT = 30,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_WEIGHT),
  parameter int unsigned DATA_WIDTH = fnn_pkg::DataWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [NUM_NEURON-1:0] wen,
  output logic [ADDR_WIDTH-1:0] wadd,
  output logic [DATA_WIDTH-1:0] win,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam int unsigned NeuronWidth = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;

  wload_state_e state_q, state_d;

  logic                   accept;
  logic                   start_acc;
  logic                   last;
  logic [ADDR_WIDTH-1:0]  addr_cnt;
  logic [NeuronWidth-1:0] neuron_cnt;

  logic [NUM_NEURON-1:0]  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0]  wadd_q;
  logic [DATA_WIDTH-1:0]  win_q;

  assign s_ready   = (state_q == StLoad);
  assign accept    = s_valid && s_ready;
  assign start_acc = (state_q == StIdle) && start;

  wload_counter #(
    .NumNeuron  (NUM_NEURON),
    .NumWeight  (NUM_WEIGHT),
    .AddrWidth  (ADDR_WIDTH),
    .NeuronWidth(NeuronWidth)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_acc),
    .advance   (accept),
    .addr_cnt  (addr_cnt),
    .neuron_cnt(neuron_cnt),
    .last      (last)
  );

  always_comb begin
    state_d = state_q;
    wen_d   = '0;
    unique case (state_q)
      StIdle:   if (start) state_d = StLoad;
      StLoad:   if (accept && last) state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (accept) wen_d = NUM_NEURON'(onehot(32'(neuron_cnt)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      wen_q   <= '0;
      wadd_q  <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      // Address and data hold between writes.
      if (accept) begin
        wadd_q <= addr_cnt;
        win_q  <= s_data;
      end
    end
  end

  assign wen  = wen_q;
  assign wadd = wadd_q;
  assign win  = win_q;
  // The final write lands in the FINISH cycle, so done lines up with it.
  assign busy = (state_q != StIdle);
  assign done = (state_q == StFinish);

`ifdef WLOAD_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q;

  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= sum_q + s_data;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule
